// File: rtl/alu_pkg.sv
// Shared definitions for the sequential EX-stage ALU: op encodings, FSM states
// and small decode helpers used by the top level and the iterative mul/div unit.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SLL    = 5'b00001;
    localparam logic [4:0] OP_SLT    = 5'b00010;
    localparam logic [4:0] OP_SLTU   = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_SUB    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01101;
    localparam logic [4:0] OP_PASSB  = 5'b01111;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic is_multicycle(input logic [4:0] op);
        return op[4] & ~op[3];
    endfunction

    // f is op[2:0] of a multi-cycle op: MULH/MULHSU/DIV/REM treat A as signed
    function automatic logic mdu_signed_a(input logic [2:0] f);
        logic r;
        case (f)
            3'b001, 3'b010, 3'b100, 3'b110: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic mdu_signed_b(input logic [2:0] f);
        logic r;
        case (f)
            3'b001, 3'b100, 3'b110: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign fix-up folded into the final step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   md_q, md_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic              sa_s, sb_s;
    logic [XLEN-1:0]   ma_s, mb_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN+1:0]   diff_s;
    logic [2*XLEN-1:0] step_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s;

    // One iteration of either algorithm plus the signed fix-up of its outcome
    always_comb begin
        sum_s    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? md_q : {XLEN{1'b0}})};
        rem_sh_s = acc_q[2*XLEN-1:XLEN-1];
        diff_s   = {1'b0, rem_sh_s} - {2'b00, md_q};
        if (op_q[2]) begin
            if (diff_s[XLEN+1]) begin
                step_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                step_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            step_s = {sum_s, acc_q[XLEN-1:1]};
        end
        prod_fix_s = qneg_q ? ({(2*XLEN){1'b0}} - step_s) : step_s;
        quo_fix_s  = qneg_q ? ({XLEN{1'b0}} - step_s[XLEN-1:0]) : step_s[XLEN-1:0];
        rem_fix_s  = rneg_q ? ({XLEN{1'b0}} - step_s[2*XLEN-1:XLEN]) : step_s[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 result = step_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quo_fix_s;
            3'b110, 3'b111:         result = rem_fix_s;
            default:                result = {XLEN{1'b0}};
        endcase
        done = (cnt_q == CNT_ONE);
    end

    // Operand magnitudes and sign flags captured at start
    always_comb begin
        sa_s = mdu_signed_a(op) & a[XLEN-1];
        sb_s = mdu_signed_b(op) & b[XLEN-1];
        ma_s = sa_s ? ({XLEN{1'b0}} - a) : a;
        mb_s = sb_s ? ({XLEN{1'b0}} - b) : b;
    end

    // Next-state: load on start, iterate while the counter runs, abort on flush
    always_comb begin
        acc_d  = acc_q;
        md_d   = md_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (flush) begin
            cnt_d = CNT_ZERO;
        end else if (start) begin
            op_d   = op;
            cnt_d  = CNT_LOAD;
            qneg_d = sa_s ^ sb_s;
            rneg_d = sa_s;
            if (op[2]) begin
                acc_d = {{XLEN{1'b0}}, ma_s};
                md_d  = mb_s;
            end else begin
                acc_d = {{XLEN{1'b0}}, mb_s};
                md_d  = ma_s;
            end
        end else if (cnt_q != CNT_ZERO) begin
            acc_d = step_s;
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= {(2*XLEN){1'b0}};
            md_q   <= {XLEN{1'b0}};
            cnt_q  <= CNT_ZERO;
            op_q   <= 3'b000;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            md_q   <= md_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU with valid/ready handshake: single-cycle ops complete
// at accept, mul/div run through the iterative unit, divide corner cases bypass it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] in_A,
    input  logic [XLEN-1:0] in_B,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            ZERO,
    output logic            busy
);

    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] X_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] X_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] X_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic [XLEN:0]   sub_s;
    logic            slt_s;
    logic [SH_W-1:0] shamt_s;
    logic [XLEN-1:0] alu_s;
    logic            div_special_s;
    logic [XLEN-1:0] div_special_val_s;
    logic [XLEN-1:0] load_val_s;
    logic            mdu_start_s;
    logic            mdu_done_s;
    logic [XLEN-1:0] mdu_result_s;

    // Single-cycle results; SLT corrects the difference sign for signed overflow
    always_comb begin
        sub_s   = {1'b0, in_A} - {1'b0, in_B};
        slt_s   = sub_s[XLEN-1] ^ ((in_A[XLEN-1] ^ in_B[XLEN-1]) & (in_A[XLEN-1] ^ sub_s[XLEN-1]));
        shamt_s = in_B[SH_W-1:0];
        case (op)
            OP_ADD:   alu_s = in_A + in_B;
            OP_SUB:   alu_s = sub_s[XLEN-1:0];
            OP_SLT:   alu_s = {{(XLEN-1){1'b0}}, slt_s};
            OP_SLTU:  alu_s = {{(XLEN-1){1'b0}}, sub_s[XLEN]};
            OP_OR:    alu_s = in_A | in_B;
            OP_AND:   alu_s = in_A & in_B;
            OP_XOR:   alu_s = in_A ^ in_B;
            OP_SLL:   alu_s = in_A << shamt_s;
            OP_SRL:   alu_s = in_A >> shamt_s;
            OP_SRA:   alu_s = $signed(in_A) >>> shamt_s;
            OP_PASSB: alu_s = in_B;
            default:  alu_s = X_ZERO;
        endcase
    end

    // Divide by zero and signed overflow finish at accept without iterating
    always_comb begin
        div_special_s = is_multicycle(op) & op[2] &
                        ((in_B == X_ZERO) | (~op[0] & (in_A == X_MIN) & (in_B == X_ONES)));
        if (in_B == X_ZERO) begin
            div_special_val_s = op[1] ? in_A : X_ONES;
        end else begin
            div_special_val_s = op[1] ? X_ZERO : X_MIN;
        end
        if (is_multicycle(op)) begin
            load_val_s = div_special_val_s;
        end else begin
            load_val_s = alu_s;
        end
    end

    // Control FSM; flush overrides everything except reset
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        mdu_start_s = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_multicycle(op) && !div_special_s) begin
                            mdu_start_s = 1'b1;
                            state_d     = S_BUSY;
                        end else begin
                            result_d = load_val_s;
                            zero_d   = (load_val_s == X_ZERO);
                            state_d  = S_DONE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (mdu_done_s) begin
                        result_d = mdu_result_s;
                        zero_d   = (mdu_result_s == X_ZERO);
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= X_ZERO;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    alu_muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (mdu_start_s),
        .op     (op[2:0]),
        .a      (in_A),
        .b      (in_B),
        .done   (mdu_done_s),
        .result (mdu_result_s)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign Result    = result_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq, checked against a plain-arithmetic
// reference of the RV32-style operation set.
module tb_alu_seq;
    import alu_pkg::*;

    localparam logic [31:0] MIN32  = 32'h8000_0000;
    localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] in_A = 32'd0;
    logic [31:0] in_B = 32'd0;
    logic        in_ready, out_valid, ZERO, busy;
    logic [31:0] Result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in_A(in_A), .in_B(in_B), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .ZERO(ZERO), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_OR:     return a | b;
            OP_AND:    return a & b;
            OP_XOR:    return a ^ b;
            OP_SLL:    return a << b[4:0];
            OP_SRL:    return a >> b[4:0];
            OP_SRA:    return $signed(a) >>> b[4:0];
            OP_PASSB:  return b;
            OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return ONES32;
                if (a == MIN32 && b == ONES32) return MIN32;
                return 32'(ia / ib);
            end
            OP_DIVU: return (b == 32'd0) ? ONES32 : a / b;
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == MIN32 && b == ONES32) return 32'd0;
                return 32'(ia % ib);
            end
            OP_REMU: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Mul/div iterate 32 steps after accept unless a divide corner case applies
    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[4] && !o[3]) begin
            if (o[2] && (b == 32'd0 || (!o[0] && a == MIN32 && b == ONES32))) return 1;
            return 33;
        end
        return 1;
    endfunction

    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int hold);
        int lat;
        bit ir_hi;
        logic [31:0] exp;
        exp = ref_alu(o, a, b);
        @(negedge clk);
        op = o; in_A = a; in_B = b; in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'($urandom); in_A = $urandom; in_B = $urandom;
        lat = 1;
        ir_hi = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_hi = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(ref_lat(o, a, b)));
        check({tag, "_result"}, Result, exp);
        check({tag, "_zero"}, {31'd0, ZERO}, {31'd0, (exp == 32'd0)});
        check({tag, "_ready_busy"}, {31'd0, ir_hi | in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_result"}, Result, exp);
            check({tag, "_hold_flags"}, {29'd0, in_ready, out_valid, ZERO}, {29'd0, 1'b0, 1'b1, (exp == 32'd0)});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [4:0] ops [0:20];
        logic [4:0] o;
        logic [31:0] a, b;
        bit seen;

        ops = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_OR, OP_AND, OP_XOR, OP_SLL, OP_SRL,
                OP_SRA, OP_PASSB, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU,
                OP_REM, OP_REMU, 5'b11000, 5'b01010};

        repeat (3) @(negedge clk);
        check("reset_outputs", {Result[30:0], ZERO}, 32'd0);
        check("reset_flags", {30'd0, out_valid, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(OP_ADD,   32'h7FFF_FFFF, 32'd1,        "add_ovf", 0);
        run_op(OP_SUB,   32'd5,         32'd5,        "sub_zero", 0);
        run_op(OP_SLT,   MIN32,         32'd1,        "slt", 0);
        run_op(OP_SLTU,  MIN32,         32'd1,        "sltu", 0);
        run_op(OP_SRA,   MIN32,         32'd4,        "sra", 0);
        run_op(OP_PASSB, 32'd0,         32'h1234,     "passb", 0);
        run_op(OP_MUL,   ONES32,        ONES32,       "mul", 10);
        run_op(OP_MULHU, ONES32,        ONES32,       "mulhu", 0);
        run_op(OP_MULH,  ONES32,        ONES32,       "mulh", 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        "div_neg", 0);
        run_op(OP_REM,   32'hFFFF_FFF9, 32'd2,        "rem_neg", 0);
        run_op(OP_DIVU,  32'd7,         32'd0,        "divu_by0", 0);
        run_op(OP_REMU,  32'd7,         32'd0,        "remu_by0", 0);
        run_op(OP_DIV,   MIN32,         ONES32,       "div_ovf", 0);
        run_op(OP_REM,   MIN32,         ONES32,       "rem_ovf", 0);

        for (int k = 0; k < 40; k++) begin
            o = ops[$urandom_range(0, 20)];
            a = ($urandom_range(0, 9) == 0) ? MIN32 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = ONES32;
                2:       b = $urandom_range(1, 40);
                default: b = $urandom;
            endcase
            run_op(o, a, b, "random", 0);
        end

        run_op(OP_ADD, 32'd1, 32'd2, "pre_flush", 0);
        @(negedge clk);
        op = OP_DIV; in_A = 32'd100; in_B = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {29'd0, in_ready, busy, out_valid}, 32'd4);
        check("flush_result_kept", Result, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);

        @(negedge clk);
        op = OP_MUL; in_A = 32'd3; in_B = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_result", Result, 32'd0);
        check("rst_mid_flags", {29'd0, ZERO, out_valid, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", {30'd0, in_ready, out_valid}, 32'd2);
        run_op(OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, "post_reset", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds AND/XOR/shift ops and an iterative RV32M-style multiply/divide unit.
- Uses a valid/ready handshake on both sides. Sits in the EX stage; the pipeline stalls on in_ready/out_valid.
- Legacy 4-bit control encodings are kept unchanged in op[3:0] with op[4]=0.

Parameters:
- XLEN, 32, operand/result width (>=8, even).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  5  operation select (encodings below).
- in_A  in  XLEN  operand A (rs1).
- in_B  in  XLEN  operand B (rs2/imm).
- flush  in  1  synchronous abort; highest priority after reset.
- out_valid  out  1  Result/ZERO valid.
- out_ready  in  1  consumer takes result.
- Result  out  XLEN  registered result.
- ZERO  out  1  registered, equals (Result==0) whenever out_valid.
- busy  out  1  state==BUSY.

Behaviour:
- Single-cycle ops, op[4]=0:
  - 00000 ADD, 01000 SUB, 00010 SLT (signed), 00011 SLTU, 00110 OR, 00111 AND, 00100 XOR.
  - 00001 SLL, 00101 SRL, 01101 SRA; shift amount is in_B[$clog2(XLEN)-1:0].
  - 01111 PASSB. Any other op[4]=0 code returns 0.
- Multi-cycle ops, op[4]=1:
  - 10000 MUL (low XLEN), 10001 MULH (s×s high), 10010 MULHSU (s×u high), 10011 MULHU (u×u high).
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU. Other op[4]=1 codes behave as single-cycle and return 0.
- SLT is computed from the XLEN+1-bit difference with overflow correction; ADD/SUB wrap modulo 2^XLEN.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept when in_valid & in_ready. Single-cycle op goes to DONE with the result registered. Multi-cycle op loads operand magnitudes and sign flags, sets cnt=XLEN, and goes to BUSY.
  - BUSY: multiply performs one shift-add step per cycle into a 2*XLEN accumulator. Divide performs one restoring shift-subtract step per cycle. cnt decrements; when cnt reaches 1, the final step applies the sign correction and the FSM goes to DONE.
  - DONE: out_valid=1. Result/ZERO are held stable until out_ready=1, then the FSM returns to IDLE. Back-to-back acceptance in the same cycle is not supported.
- Latency from the accept edge to out_valid high:
  - single-cycle ops: 1 cycle;
  - multi-cycle ops: XLEN+1 cycles.
- Divide special cases, checked at accept; the FSM goes straight to DONE in 1 cycle:
  - B==0: DIV/DIVU quotient = all ones; REM/REMU = in_A.
  - Signed overflow (A=most-negative, B=−1): DIV = most-negative; REM = 0.
- Remainder sign follows the dividend; quotient sign = sA^sB.
- flush=1 forces IDLE next cycle from any state and clears out_valid. Result keeps its last value; ZERO is recomputed only on the next load.
- Reset values: state=IDLE, out_valid=0, Result=0, ZERO=0, busy=0, internal accumulators=0, cnt=0. in_ready=1 after reset release.
- Reset asserted mid-BUSY aborts immediately and asynchronously; no partial result is ever presented.
- Operands are captured at accept; in_A/in_B/op may change freely afterwards.

Decomposition:
- Package alu_pkg holds:
  - the op encoding constants (OP_ADD..OP_REMU) and the state enum (S_IDLE, S_BUSY, S_DONE);
  - the helper function is_multicycle(op).
- Sub-module alu_muldiv_iter holds the iterative multiply/divide datapath: start/op/operands in, done/result out, XLEN-step counter inside. The top level keeps the FSM, handshake and single-cycle ops.

Test Plan:
- ADD 0x7FFFFFFF+1 → Result=0x80000000, ZERO=0, out_valid 1 cycle after accept. SUB 5−5 → Result=0, ZERO=1.
- SLT A=0x80000000, B=1 → 1. SLTU same operands → 0. SRA 0x80000000 by 4 → 0xF8000000. PASSB B=0x1234 → 0x1234.
- MUL 0xFFFFFFFF×0xFFFFFFFF:
  - MUL → 0x00000001, MULHU → 0xFFFFFFFE, MULH → 0x00000000.
  - out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU 7/0 → 0xFFFFFFFF, REMU 7/0 → 7. DIV 0x80000000/−1 → 0x80000000 in 1 cycle.
- Backpressure: out_ready held low 10 cycles in DONE → Result stable, in_ready=0. out_ready high → IDLE next cycle, in_ready=1.
- flush at BUSY cycle 5 → IDLE next cycle, out_valid never asserted. Then rst_n pulsed low mid-BUSY → all outputs at reset values immediately.
